// File: rtl/cla_pkg.sv
// cla_pkg: shared lookahead types and the 4-bit group propagate/generate helper
// Contents: CLA_GROUP (bits per lookahead group), pg_t (per-bit p/g pair),
//           group_pg (group GP = &p, group GG = lookahead generate over 4 bits).
package cla_pkg;
  localparam int CLA_GROUP = 4;
  typedef struct packed {
    logic p;
    logic g;
  } pg_t;
  function automatic pg_t group_pg(input pg_t [3:0] t);
    return pg_t'{
      p: t[3].p & t[2].p & t[1].p & t[0].p,
      g: t[3].g | (t[3].p & t[2].g) | (t[3].p & t[2].p & t[1].g) |
         (t[3].p & t[2].p & t[1].p & t[0].g)
    };
  endfunction
endpackage

// File: rtl/cla_lookahead4.sv
// cla_lookahead4: combinational 4-bit carry-lookahead group
// Ports: p/g = per-bit propagate/generate, ci = group carry in,
//        c[4:1] = carries out of each bit, gp/gg = group propagate/generate.
module cla_lookahead4
  import cla_pkg::*;
(
  input  logic [3:0] p,
  input  logic [3:0] g,
  input  logic       ci,
  output logic [4:1] c,
  output logic       gp,
  output logic       gg
);
  pg_t [3:0] t;
  pg_t       grp;
  assign t = {p[3], g[3], p[2], g[2], p[1], g[1], p[0], g[0]};
  assign grp = group_pg(t);
  assign gp = grp.p;
  assign gg = grp.g;
  assign c[1] = g[0] | (p[0] & ci);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
  // Carry out of the group is the inter-group ripple term GG | GP & Cg.
  assign c[4] = gg | (gp & ci);
endmodule

// File: rtl/cla_add_pipe.sv
// cla_add_pipe: two-stage pipelined carry-lookahead adder/subtractor with valid/ready
// Ports: clk, rst (sync, active-high); in_valid/in_ready + a, b, cin, sub operand beat;
//        out_valid/out_ready + sum, cout, ovf, zero result beat.
// Optional macro CLA_BLOCK_PG_EN adds registered bp/bg block propagate/generate outputs.
module cla_add_pipe
  import cla_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int GROUP = CLA_GROUP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
`ifdef CLA_BLOCK_PG_EN
  ,
  output logic             bp,
  output logic             bg
`endif
);
  localparam int NG = WIDTH / GROUP;
  logic             s1_valid_q, s1_valid_d, out_valid_q, out_valid_d;
  logic [WIDTH-1:0] hs_q, hs_d, p_q, p_d, g_q, g_d, sum_q, sum_d;
  logic [WIDTH-1:0] bb, sum_c;
  logic             c0_q, c0_d, cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;
  logic             s2_adv, s1_adv, acc;
  logic [WIDTH:0]   c;
  logic [NG-1:0]    gp, gg;
  assign s2_adv = !out_valid_q | out_ready;
  assign s1_adv = s1_valid_q & s2_adv;
  assign in_ready = !s1_valid_q | s2_adv;
  assign acc = in_valid & in_ready;
  assign bb = b ^ {WIDTH{sub}};
  always_comb begin
    s1_valid_d = acc | (s1_valid_q & !s1_adv);
    hs_d = acc ? a ^ bb : hs_q;
    p_d = acc ? a | bb : p_q;
    g_d = acc ? a & bb : g_q;
    c0_d = acc ? sub | cin : c0_q;
  end
  assign c[0] = c0_q;
  for (genvar k = 0; k < NG; k++) begin : g_grp
    cla_lookahead4 u_la (
      .p (p_q[GROUP*k +: GROUP]),
      .g (g_q[GROUP*k +: GROUP]),
      .ci(c[GROUP*k]),
      .c (c[GROUP*k+1 +: GROUP]),
      .gp(gp[k]),
      .gg(gg[k])
    );
  end
  assign sum_c = hs_q ^ c[WIDTH-1:0];
  always_comb begin
    out_valid_d = s1_adv | (out_valid_q & !out_ready);
    sum_d = s1_adv ? sum_c : sum_q;
    cout_d = s1_adv ? c[WIDTH] : cout_q;
    ovf_d = s1_adv ? c[WIDTH-1] ^ c[WIDTH] : ovf_q;
    zero_d = s1_adv ? ~|sum_c : zero_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      hs_q <= '0;
      p_q <= '0;
      g_q <= '0;
      c0_q <= 1'b0;
      out_valid_q <= 1'b0;
      sum_q <= '0;
      cout_q <= 1'b0;
      ovf_q <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      hs_q <= hs_d;
      p_q <= p_d;
      g_q <= g_d;
      c0_q <= c0_d;
      out_valid_q <= out_valid_d;
      sum_q <= sum_d;
      cout_q <= cout_d;
      ovf_q <= ovf_d;
      zero_q <= zero_d;
    end
  end
  assign out_valid = out_valid_q;
  assign sum = sum_q;
  assign cout = cout_q;
  assign ovf = ovf_q;
  assign zero = zero_q;
`ifdef CLA_BLOCK_PG_EN
  logic [NG:0] bgc;
  logic        bp_q, bp_d, bg_q, bg_d;
  // Block generate ripples the group terms with the carry in forced to 0.
  assign bgc[0] = 1'b0;
  for (genvar k = 0; k < NG; k++) begin : g_blk
    assign bgc[k+1] = gg[k] | (gp[k] & bgc[k]);
  end
  always_comb begin
    bp_d = s1_adv ? &gp : bp_q;
    bg_d = s1_adv ? bgc[NG] : bg_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      bp_q <= 1'b0;
      bg_q <= 1'b0;
    end else begin
      bp_q <= bp_d;
      bg_q <= bg_d;
    end
  end
  assign bp = bp_q;
  assign bg = bg_q;
`else
  logic unused_pg;
  assign unused_pg = ^{gp, gg};
`endif
endmodule

// File: tb/tb_cla_add_pipe.sv
// tb_cla_add_pipe: directed and random self-checking bench for cla_add_pipe
module tb_cla_add_pipe;
  localparam int W = 16;
  typedef struct packed {
    logic [W-1:0] sum;
    logic cout;
    logic ovf;
    logic zero;
    logic bp;
    logic bg;
  } res_t;
  logic clk = 1'b0;
  logic rst, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf, zero;
  logic [W-1:0] a, b, sum;
`ifdef CLA_BLOCK_PG_EN
  logic bp, bg;
`endif
  int checks = 0;
  int errors = 0;
  int nres = 0;
  res_t q[$];
  logic rnd_on = 1'b0;
  always #5 clk = ~clk;
  cla_add_pipe #(.WIDTH(W), .GROUP(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
`ifdef CLA_BLOCK_PG_EN
    , .bp(bp), .bg(bg)
`endif
  );
  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci, input logic s);
    logic [W-1:0] yb;
    logic [W:0] full, blk;
    res_t r;
    yb = s ? ~y : y;
    full = {1'b0, x} + {1'b0, yb} + {{W{1'b0}}, s | ci};
    blk = {1'b0, x} + {1'b0, yb};
    r.sum = full[W-1:0];
    r.cout = full[W];
    r.ovf = (x[W-1] == yb[W-1]) && (r.sum[W-1] != x[W-1]);
    r.zero = (r.sum == '0);
    r.bp = &(x | yb);
    r.bg = blk[W];
    return r;
  endfunction
  function automatic logic [W-1:0] pick();
    int k;
    k = int'($urandom_range(0, 7));
    case (k)
      0: return 16'hFFFF;
      1: return 16'h8000;
      2: return 16'h7FFF;
      3: return 16'h0000;
      default: return W'($urandom);
    endcase
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (rst) q.delete();
    else begin
      if (out_valid) begin
        if (q.size() == 0) chk("spurious_out_valid", 64'(out_valid), 64'(0));
        else begin
          chk("result", 64'({sum, cout, ovf, zero}), 64'({q[0].sum, q[0].cout, q[0].ovf, q[0].zero}));
`ifdef CLA_BLOCK_PG_EN
          chk("block_pg", 64'({bp, bg}), 64'({q[0].bp, q[0].bg}));
`endif
          if (out_ready) begin
            void'(q.pop_front());
            nres++;
          end
        end
      end
      if (in_valid && in_ready) q.push_back(model(a, b, cin, sub));
    end
  end
  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci, input logic s);
    int n = 0;
    logic ok = 1'b0;
    in_valid = 1'b1;
    a = x;
    b = y;
    cin = ci;
    sub = s;
    do begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 200);
    if (!ok) chk("send_timeout", 64'(ok), 64'(1));
    in_valid = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    cin = 1'($urandom_range(0, 1));
    sub = 1'($urandom_range(0, 1));
  endtask
  task automatic dir(input string name, input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                     input logic s, input logic [W-1:0] es, input logic ec, input logic eo, input logic ez);
    res_t m;
    m = model(x, y, ci, s);
    chk({name, "_model"}, 64'({m.sum, m.cout, m.ovf, m.zero}), 64'({es, ec, eo, ez}));
    send(x, y, ci, s);
    chk({name, "_lat1_valid"}, 64'(out_valid), 64'(0));
    @(posedge clk);
    #1;
    chk({name, "_lat2_valid"}, 64'(out_valid), 64'(1));
    chk({name, "_dut"}, 64'({sum, cout, ovf, zero}), 64'({es, ec, eo, ez}));
  endtask
  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1);
  end
  initial begin
    int n0;
    rst = 1'b1;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
    sub = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_outputs", 64'({sum, cout, ovf, zero}), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    rst = 1'b0;
    dir("add", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0);
    dir("wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    dir("ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    dir("sub_borrow", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    dir("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
    dir("sub_cin_ignored", 16'h0005, 16'h0005, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
    dir("cin_carry", 16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0);
    dir("neg_ovf", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    n0 = nres;
    fork
      begin
        for (int i = 1; i <= 4; i++) send(W'(i), W'(i), 1'b0, 1'b0);
      end
      begin
        int n = 0;
        do begin
          @(posedge clk);
          #1;
          n++;
        end while (!out_valid && n < 20);
        out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("bp_in_ready", 64'(in_ready), 64'(0));
        chk("bp_out_valid", 64'(out_valid), 64'(1));
        chk("bp_hold_sum", 64'(sum), 64'(16'h0002));
        out_ready = 1'b1;
      end
    join
    repeat (4) @(posedge clk);
    #1;
    chk("bp_result_count", 64'(nres - n0), 64'(4));
    send(16'h0010, 16'h0020, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rstmid_in_ready", 64'(in_ready), 64'(1));
    for (int i = 0; i < 3; i++) begin
      chk("rstmid_out_valid", 64'(out_valid), 64'(0));
      chk("rstmid_sum", 64'(sum), 64'(0));
      @(posedge clk);
      #1;
    end
    dir("after_rst", 16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rnd_on = 1'b1;
    fork
      begin
        while (rnd_on) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join_none
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      send(pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    rnd_on = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    begin
      int n = 0;
      while (q.size() != 0 && n < 50) begin
        @(posedge clk);
        #1;
        n++;
      end
    end
    chk("drain_empty", 64'(q.size()), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    chk("final_idle", 64'(out_valid), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
